// File: rtl/mul_pass_seq_ctrl.sv
// mul_pass_seq_ctrl: multi-pass sequencer for an unsigned OP_W x OP_W multiply.
// It time-shares one external 16-row reduction tree and accumulates through a 64-bit CPA.
// Latency: NUM_PASS+1 cycles from the accept edge to out_valid (OP_W/16 passes plus a present cycle).
// Backpressure: in_ready is low while busy. out_valid/out_prod hold until out_ready.
// Ports:
//   clk, rst (sync, active-high)           - clock and reset
//   in_valid/in_ready, in_a, in_b          - operand handshake
//   out_valid/out_ready, out_prod          - product handshake (upper 64-2*OP_W bits zero)
//   busy                                   - high in any state other than IDLE
//   tree_pp, tree_p16 -> tree_sum, tree_carry - external tree (carry weight is <<1)
module mul_pass_seq_ctrl #(
  parameter int OP_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_prod,
  output logic              busy,
  output logic [1023:0]     tree_pp,
  output logic [63:0]       tree_p16,
  input  logic [63:0]       tree_sum,
  input  logic [63:0]       tree_carry
);

  localparam int   NUM_PASS  = OP_W / 16;
  localparam logic LAST_PASS = 1'(NUM_PASS - 1);

  if (OP_W != 16 && OP_W != 32) begin : g_bad_op_w
    $error("mul_pass_seq_ctrl: OP_W must be 16 or 32");
  end

  typedef enum logic [1:0] {IDLE, PASS, DONE} state_t;

  state_t            state;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic [63:0]       acc;
  logic              pass_cnt;

  logic [63:0]       a_ext;
  logic [31:0]       b_ext;
  logic [63:0]       cpa;

  assign a_ext    = 64'(a_q);
  assign b_ext    = 32'(b_q);
  assign out_prod = acc;

  // Resolve the redundant tree output; carries beyond bit 63 are dropped.
  assign cpa = tree_sum + {tree_carry[62:0], 1'b0};

  // Partial-product rows for the current pass. Multiplier bit index and
  // shift amount are both {pass_cnt, j}, i.e. 16*pass_cnt + j.
  // Tree inputs are held at zero outside PASS.
  always_comb begin
    tree_pp  = '0;
    tree_p16 = '0;
    if (state == PASS) begin
      tree_p16 = acc;
      for (int j = 0; j < 16; j++) begin
        if (b_ext[{pass_cnt, 4'(j)}]) begin
          tree_pp[64*j +: 64] = a_ext << {pass_cnt, 4'(j)};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      pass_cnt  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= in_a;
            b_q      <= in_b;
            acc      <= '0;
            pass_cnt <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= PASS;
          end
        end
        PASS: begin
          acc <= cpa;
          if (pass_cnt == LAST_PASS) begin
            state <= DONE;
          end else begin
            pass_cnt <= pass_cnt + 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle raises the registered out_valid from the settled
          // accumulator; afterwards it is held until the consumer takes it.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
